// File: rtl/featuremap_pad_pkg.sv
// featuremap_pad_pkg: shared types and constants for the feature-map pad writer.
//   state_t  : writer FSM states
//   PAD_WORD : word written on every padded border position (IEEE-754 +0.0)
package featuremap_pad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PAD_ROW,
        PAD_L,
        DATA,
        PAD_R,
        DONE
    } state_t;

    localparam logic [31:0] PAD_WORD = 32'h0000_0000;

endpackage

// File: rtl/featuremap_pad_writer_if.sv
// featuremap_pad_writer_if: stream and FIFO-write signals of the pad writer.
//   valid_in/data_in/ready_out : unpadded raster stream from the producer
//   fifo_full/wrreq/data_out   : write port of the downstream per-channel FIFO
// Modports:
//   master : the pad writer (consumes the stream, drives the FIFO write)
//   slave  : the environment (producer plus FIFO)
interface featuremap_pad_writer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ready_out;
    logic                  fifo_full;
    logic                  wrreq;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        input  valid_in, data_in, fifo_full,
        output ready_out, wrreq, data_out
    );

    modport slave (
        output valid_in, data_in, fifo_full,
        input  ready_out, wrreq, data_out
    );
endinterface

// File: rtl/pad_raster_counter.sv
// pad_raster_counter: row/column position inside the padded
// (WIDTH+2) x (HEIGHT+2) frame.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : return to (0,0) at the start of a frame
//   advance   : one word was written; step to the next position
//   row, col  : current padded position
//   is_pad    : current position is on the zero border
//   last_col  : col == WIDTH+1
//   last_row  : row == HEIGHT+1
module pad_raster_counter #(
    parameter int WIDTH  = 56,
    parameter int HEIGHT = 56
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        advance,
    output logic [$clog2(HEIGHT+2)-1:0] row,
    output logic [$clog2(WIDTH+2)-1:0]  col,
    output logic                        is_pad,
    output logic                        last_col,
    output logic                        last_row
);
    localparam int CW = $clog2(WIDTH+2);
    localparam int RW = $clog2(HEIGHT+2);

    assign last_col = (col == CW'(WIDTH+1));
    assign last_row = (row == RW'(HEIGHT+1));
    assign is_pad   = (row == '0) || last_row || (col == '0) || last_col;

    // The row may wrap past HEIGHT+1 on the final beat; the next start
    // clears it before it is looked at again.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (last_col) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end
endmodule

// File: rtl/featuremap_pad_writer.sv
// featuremap_pad_writer: writes one channel's WIDTH x HEIGHT raster into the
// downstream FIFO as a 1-pixel zero-padded (WIDTH+2) x (HEIGHT+2) frame.
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle pulse, begins a frame (only honoured in IDLE)
//   bus        : producer stream (valid_in/data_in/ready_out) and
//                FIFO write (fifo_full/wrreq/data_out)
//   busy       : frame in progress
//   frame_done : one-cycle pulse after the last word of a frame
// Optional macro FEATUREMAP_PAD_SKID_EN: one-entry input skid register,
// registered ready_out (no fifo_full -> ready_out combinational path).
module featuremap_pad_writer
    import featuremap_pad_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 56,
    parameter int HEIGHT     = 56
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    featuremap_pad_writer_if.master      bus,
    output logic                         busy,
    output logic                         frame_done
);
    localparam int CW = $clog2(WIDTH+2);
    localparam int RW = $clog2(HEIGHT+2);

    state_t                state, state_nxt;
    logic [RW-1:0]         row;
    logic [CW-1:0]         col;
    logic                  is_pad, last_col, last_row;
    logic                  in_frame, beat, data_beat;
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_data;

    assign in_frame  = (state == PAD_ROW) || (state == PAD_L) ||
                       (state == DATA)    || (state == PAD_R);
    assign beat      = in_frame && !bus.fifo_full && (is_pad || src_valid);
    assign data_beat = beat && (state == DATA);

`ifdef FEATUREMAP_PAD_SKID_EN
    logic                  skid_vld;
    logic [DATA_WIDTH-1:0] skid_data;

    // A held word always goes out ahead of anything new on data_in.
    assign src_valid     = skid_vld || bus.valid_in;
    assign src_data      = skid_vld ? skid_data : bus.data_in;
    assign bus.ready_out = !skid_vld;

    // While empty every offered pixel is taken; the ones not written
    // straight through this cycle land in the skid.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_vld  <= 1'b0;
            skid_data <= '0;
        end else if (skid_vld) begin
            if (data_beat)
                skid_vld <= 1'b0;
        end else if (bus.valid_in && !data_beat) begin
            skid_vld  <= 1'b1;
            skid_data <= bus.data_in;
        end
    end
`else
    assign src_valid     = bus.valid_in;
    assign src_data      = bus.data_in;
    assign bus.ready_out = (state == DATA) && !bus.fifo_full;
`endif

    assign bus.wrreq    = beat;
    assign bus.data_out = is_pad ? DATA_WIDTH'(PAD_WORD) : src_data;
    assign busy         = (state != IDLE);
    assign frame_done   = (state == DONE);

    pad_raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    ((state == IDLE) && start),
        .advance  (beat),
        .row      (row),
        .col      (col),
        .is_pad   (is_pad),
        .last_col (last_col),
        .last_row (last_row)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PAD_ROW;
            PAD_ROW: if (beat && last_col) state_nxt = last_row ? DONE : PAD_L;
            PAD_L:   if (beat) state_nxt = DATA;
            DATA:    if (beat && (col == CW'(WIDTH))) state_nxt = PAD_R;
            PAD_R:   if (beat) state_nxt = (row == RW'(HEIGHT)) ? PAD_ROW : PAD_L;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_featuremap_pad_writer.sv
module tb_featuremap_pad_writer;
    localparam int DW = 32;
    localparam int W  = 3;
    localparam int H  = 2;
    localparam int NPIX = W * H;

`ifdef FEATUREMAP_PAD_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk, rst, start, busy, frame_done;
    featuremap_pad_writer_if #(.DATA_WIDTH(DW)) bus();

    featuremap_pad_writer #(.DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus.master),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];
    int cyc = 0, last_wr = -10, wr_cnt = 0, tot_wr = 0, done_cnt = 0;
    int pix_idx = 0;
    bit done_seen = 0, prod_on = 0;
    bit stall_en = 0, stall_used = 0, gap_en = 0, gap_used = 0;
    int stall_left = 0, gap_left = 0, full_mode = 0;
    bit cur_gap = 0;
    logic ro_edge = 0;

    function automatic logic [31:0] fbits(input int k);
        case (k)
            1: return 32'h3F80_0000;
            2: return 32'h4000_0000;
            3: return 32'h4040_0000;
            4: return 32'h4080_0000;
            5: return 32'h40A0_0000;
            6: return 32'h40C0_0000;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Expected padded frame built from the pixel numbering alone.
    task automatic push_frame();
        for (int r = 0; r < H + 2; r++)
            for (int c = 0; c < W + 2; c++)
                if (r == 0 || r == H + 1 || c == 0 || c == W + 1) exp_q.push_back('0);
                else exp_q.push_back(fbits((r - 1) * W + c));
    endtask

    task automatic drive_inputs();
        if (stall_en && !stall_used && wr_cnt == 7) begin
            stall_used = 1;
            stall_left = 3;
        end
        if (gap_en && !gap_used && wr_cnt == 12) begin
            gap_used = 1;
            gap_left = 4;
        end
        cur_gap = (gap_left > 0);
        if (cur_gap) gap_left--;
        case (full_mode)
            2:       bus.fifo_full = cyc[0];
            default: begin
                bus.fifo_full = (stall_left > 0);
                if (stall_left > 0) stall_left--;
            end
        endcase
        bus.valid_in = prod_on && !cur_gap && (pix_idx < NPIX);
        bus.data_in  = bus.valid_in ? fbits(pix_idx + 1) : 32'hDEAD_BEEF;
    endtask

    task automatic step();
        logic fire;
        @(negedge clk);
        fire = bus.valid_in && bus.ready_out;
        if (bus.wrreq) begin
            if (exp_q.size() == 0) chk("spurious_write", 1'b1, 1'b0);
            else chk("data_out", bus.data_out, exp_q.pop_front());
            wr_cnt++;
            tot_wr++;
            last_wr = cyc;
        end
        if (bus.fifo_full) chk("wrreq_when_full", bus.wrreq, 1'b0);
        if (!SKID && bus.fifo_full) chk("ready_when_full", bus.ready_out, 1'b0);
        if (!SKID && cur_gap) chk("wrreq_in_gap", bus.wrreq, 1'b0);
        if (SKID) chk("ready_registered", bus.ready_out, ro_edge);
        if (frame_done) begin
            done_cnt++;
            done_seen = 1;
            chk("done_latency", cyc, last_wr + 1);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (fire) pix_idx++;
        ro_edge = bus.ready_out;
        drive_inputs();
    endtask

    // start is driven together with rst: reset must win.
    task automatic reset_dut();
        prod_on = 0;
        bus.valid_in = 0;
        bus.fifo_full = 0;
        rst = 1;
        start = 1;
        @(negedge clk);
        @(posedge clk);
        #1;
        cyc++;
        rst = 0;
        start = 0;
        exp_q.delete();
        pix_idx = 0;
        wr_cnt = 0;
        @(negedge clk);
        chk("rst_wrreq", bus.wrreq, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_ready", bus.ready_out, SKID);
        @(posedge clk);
        #1;
        cyc++;
        ro_edge = bus.ready_out;
        prod_on = 1;
        drive_inputs();
    endtask

    task automatic run_frame(input bit mid_start);
        push_frame();
        wr_cnt = 0;
        pix_idx = 0;
        done_seen = 0;
        stall_used = 0;
        gap_used = 0;
        start = 1;
        step();
        start = 0;
        chk("busy_after_start", busy, 1'b1);
        for (int k = 0; k < 200 && !done_seen; k++) begin
            start = (mid_start && k == 5);
            step();
        end
        start = 0;
        chk("frame_done_seen", done_seen, 1'b1);
        chk("frame_writes", wr_cnt, 20);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int d0, w0;
        rst = 0;
        start = 0;
        bus.valid_in = 0;
        bus.data_in = '0;
        bus.fifo_full = 0;
        @(posedge clk);
        #1;
        reset_dut();

        run_frame(0);

        stall_en = 1;
        run_frame(0);
        stall_en = 0;

        gap_en = 1;
        run_frame(0);
        gap_en = 0;

        // Abandon a frame at beat 8, then a clean frame must follow.
        push_frame();
        wr_cnt = 0;
        pix_idx = 0;
        start = 1;
        step();
        start = 0;
        for (int k = 0; k < 100 && wr_cnt < 8; k++) step();
        chk("reached_beat8", wr_cnt, 8);
        reset_dut();
        run_frame(0);

        // Start while busy is ignored; back-to-back frames.
        d0 = done_cnt;
        w0 = tot_wr;
        run_frame(1);
        run_frame(0);
        chk("b2b_done_pulses", done_cnt - d0, 2);
        chk("b2b_writes", tot_wr - w0, 40);

        full_mode = 2;
        run_frame(0);
        full_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
